// File: rtl/control_unit_if.sv
// Sequencer-side bus of the control unit: program-memory fetch, ALU/regfile
// controls and the register write select/enable pair.
interface control_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic                   imem_valid;
    logic                   zero;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [2:0]             rd_a_sel;
    logic [2:0]             rd_b_sel;
    logic [7:0]             imm;
    logic                   imm_sel;
    logic [3:0]             alu_op;
    logic [2:0]             reg_sel;
    logic                   reg_en;
    logic                   halted;
    logic                   illegal;

    modport master (
        input  imem_instr, imem_valid, zero,
        output imem_req, imem_addr, rd_a_sel, rd_b_sel, imm, imm_sel,
               alu_op, reg_sel, reg_en, halted, illegal
    );

    modport slave (
        output imem_instr, imem_valid, zero,
        input  imem_req, imem_addr, rd_a_sel, rd_b_sel, imm, imm_sel,
               alu_op, reg_sel, reg_en, halted, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Instruction sequencer: fetch/decode/execute/writeback FSM driving the ALU,
// register-file read selects and the write-enable decoder.
module control_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   imem_req;
    logic                   reg_en;
    logic                   halted;
    logic                   illegal;
    logic [3:0]             op;
    logic [PC_WIDTH-1:0]    target;

    assign op     = ir[15:12];
    assign target = PC_WIDTH'(ir[7:0]);

    // Field decodes come straight off IR, which only loads on the edge into
    // DECODE, so they hold from one DECODE to the next and reset to zero.
    assign bus.rd_a_sel  = ir[8:6];
    assign bus.rd_b_sel  = ir[5:3];
    assign bus.imm       = ir[7:0];
    assign bus.imm_sel   = (op == OP_LDI);
    assign bus.alu_op    = op;
    assign bus.reg_sel   = ir[11:9];
    assign bus.imem_addr = pc;
    assign bus.imem_req  = imem_req;
    assign bus.reg_en    = reg_en;
    assign bus.halted    = halted;
    assign bus.illegal   = illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            imem_req <= 1'b0;
            reg_en   <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // First cycle out of reset only raises the request.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (bus.imem_valid) begin
                        ir       <= bus.imem_instr;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    illegal <= (op inside {[4'h9:4'hE]});
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    illegal <= 1'b0;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
                            reg_en <= 1'b1;
                            state  <= S_WB;
                        end
                        OP_JMP: begin
                            pc       <= target;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_JZ: begin
                            pc       <= bus.zero ? target : pc + 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            // NOP and undefined opcodes just advance.
                            pc       <= pc + 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_WB: begin
                    reg_en   <= 1'b0;
                    pc       <= pc + 1'b1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, ALU/LDI timing, fetch stall,
// branches with PC wrap, illegal/halt, and reset during writeback.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    control_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus();

    control_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Presents one instruction at the current FETCH cycle and runs ncyc cycles.
    task automatic run_instr(input logic [15:0] ins, input logic z, input int ncyc,
                             output int en_cnt, output int ill_cnt);
        en_cnt  = 0;
        ill_cnt = 0;
        bus.zero       = z;
        bus.imem_instr = ins;
        bus.imem_valid = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            bus.imem_valid = 1'b0;
            if (bus.reg_en)  en_cnt++;
            if (bus.illegal) ill_cnt++;
        end
    endtask

    task automatic test_reset();
        logic [35:0] outs;
        rst = 1'b1;
        repeat (2) begin
            bus.imem_instr = 16'($urandom);
            bus.imem_valid = 1'($urandom);
            bus.zero       = 1'($urandom);
            @(negedge clk);
        end
        outs = {bus.imem_req, bus.reg_en, bus.reg_sel, bus.rd_a_sel, bus.rd_b_sel,
                bus.imm, bus.imm_sel, bus.alu_op, bus.halted, bus.illegal, bus.imem_addr};
        checks++;
        if (outs !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst = 1'b0;
        bus.imem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_release: req/addr got %b/%h, expected 1/00", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_add();
        bus.zero       = 1'b0;
        bus.imem_instr = 16'h1650;
        bus.imem_valid = 1'b1;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        checks++;
        if ({bus.rd_a_sel, bus.rd_b_sel, bus.alu_op, bus.imm_sel, bus.imem_req, bus.reg_en}
            !== {3'd1, 3'd2, 4'd1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_decode: a=%0d b=%0d op=%h isel=%b req=%b en=%b, expected 1 2 1 0 0 0",
                     bus.rd_a_sel, bus.rd_b_sel, bus.alu_op, bus.imm_sel, bus.imem_req, bus.reg_en);
        end
        @(negedge clk);
        checks++;
        if ({bus.reg_en, bus.rd_a_sel, bus.alu_op} !== {1'b0, 3'd1, 4'd1}) begin
            errors++;
            $display("FAIL add_exec: en=%b a=%0d op=%h, expected 0 1 1", bus.reg_en, bus.rd_a_sel, bus.alu_op);
        end
        @(negedge clk);
        checks++;
        if ({bus.reg_en, bus.reg_sel, bus.imem_addr} !== {1'b1, 3'd3, 8'h00}) begin
            errors++;
            $display("FAIL add_wb: en=%b sel=%0d addr=%h, expected 1 3 00", bus.reg_en, bus.reg_sel, bus.imem_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.reg_en, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL add_next: en=%b req=%b addr=%h, expected 0 1 01", bus.reg_en, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_fetch_stall();
        int req_hi   = 0;
        int en_other = 0;
        bit en_at7   = 0;
        bus.imem_instr = 16'h6A2C;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 7 && bus.imem_req) req_hi++;
            if (bus.reg_en) begin
                if (c == 7) en_at7 = 1'b1;
                else        en_other++;
            end
            if (c == 5) begin
                checks++;
                if ({bus.imm, bus.imm_sel} !== {8'h2C, 1'b1}) begin
                    errors++;
                    $display("FAIL ldi_decode: imm=%h isel=%b, expected 2c 1", bus.imm, bus.imm_sel);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.reg_sel !== 3'd5) begin
                    errors++;
                    $display("FAIL ldi_wb_sel: got %0d, expected 5", bus.reg_sel);
                end
            end
            bus.imem_valid = (c == 4);
            @(negedge clk);
        end
        checks++;
        if (req_hi != 4) begin
            errors++;
            $display("FAIL stall_req_cycles: got %0d, expected 4", req_hi);
        end
        checks++;
        if (!en_at7 || en_other != 0) begin
            errors++;
            $display("FAIL stall_reg_en: at7=%b others=%0d, expected 1 0", en_at7, en_other);
        end
        checks++;
        if (bus.imem_addr !== 8'h02) begin
            errors++;
            $display("FAIL stall_pc: got %h, expected 02", bus.imem_addr);
        end
    endtask

    task automatic test_branches();
        int en, ill;
        run_instr(16'h8040, 1'b1, 3, en, ill);
        checks++;
        if (bus.imem_addr !== 8'h40 || en != 0) begin
            errors++;
            $display("FAIL jz_taken: addr=%h en_pulses=%0d, expected 40 0", bus.imem_addr, en);
        end
        run_instr(16'h8040, 1'b0, 3, en, ill);
        checks++;
        if (bus.imem_addr !== 8'h41 || en != 0) begin
            errors++;
            $display("FAIL jz_not_taken: addr=%h en_pulses=%0d, expected 41 0", bus.imem_addr, en);
        end
        run_instr(16'h70FF, 1'b0, 3, en, ill);
        checks++;
        if (bus.imem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL jmp: addr=%h, expected ff", bus.imem_addr);
        end
        run_instr(16'h0000, 1'b0, 3, en, ill);
        checks++;
        if ({bus.imem_addr, bus.imem_req} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL nop_wrap: addr=%h req=%b, expected 00 1", bus.imem_addr, bus.imem_req);
        end
    endtask

    task automatic test_illegal_halt();
        int en, ill;
        int bad = 0;
        run_instr(16'hA123, 1'b0, 3, en, ill);
        checks++;
        if (ill != 1 || en != 0 || bus.imem_addr !== 8'h01 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal: pulses=%0d en=%0d addr=%h, expected 1 0 01", ill, en, bus.imem_addr);
        end
        run_instr(16'hF000, 1'b0, 3, en, ill);
        checks++;
        if ({bus.halted, bus.imem_req, bus.imem_addr} !== {1'b1, 1'b0, 8'h01}) begin
            errors++;
            $display("FAIL halt_enter: halted=%b req=%b addr=%h, expected 1 0 01",
                     bus.halted, bus.imem_req, bus.imem_addr);
        end
        for (int i = 0; i < 22; i++) begin
            bus.imem_valid = 1'b1;
            bus.imem_instr = 16'h1650;
            bus.zero       = 1'($urandom);
            @(negedge clk);
            if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.reg_en !== 1'b0 || bus.imem_addr !== 8'h01)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_hold: %0d bad cycles, expected 0", bad);
        end
        bus.imem_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.halted, bus.imem_addr} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL halt_reset: halted=%b addr=%h, expected 0 00", bus.halted, bus.imem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wb();
        int en, ill;
        run_instr(16'h0000, 1'b0, 3, en, ill);
        bus.imem_instr = 16'h1650;
        bus.imem_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.imem_valid = 1'b0;
        end
        checks++;
        if ({bus.reg_en, bus.imem_addr} !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL midwb_pre: en=%b addr=%h, expected 1 01", bus.reg_en, bus.imem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.reg_en, bus.imem_addr, bus.imem_req} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL midwb_reset: en=%b addr=%h req=%b, expected 0 00 0",
                     bus.reg_en, bus.imem_addr, bus.imem_req);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL midwb_refetch: req=%b, expected 1", bus.imem_req);
        end
        run_instr(16'h6A2C, 1'b0, 4, en, ill);
        checks++;
        if (en != 1 || bus.imem_addr !== 8'h01) begin
            errors++;
            $display("FAIL midwb_resume: en_pulses=%0d addr=%h, expected 1 01", en, bus.imem_addr);
        end
    endtask

    initial begin
        bus.imem_instr = '0;
        bus.imem_valid = 1'b0;
        bus.zero       = 1'b0;
        test_reset();
        test_add();
        test_fetch_stall();
        test_branches();
        test_illegal_halt();
        test_reset_mid_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 8-register microprocessor. It fetches 16-bit instructions from program memory and steps each one through a fetch/decode/execute/writeback state machine. It drives the ALU opcode and the register-file read selects. It also produces the 3-bit register write select and the write enable that feed the downstream 3-to-8 write-enable decoder, so every register write in the core is launched from this block.

## Interface
- PC_WIDTH, 8, program counter and instruction-address width.
- INSTR_WIDTH, 16, instruction word width. Only 16 is supported.
- CLK  input  1  single clock. All state changes on the rising edge.
- RST  input  1  synchronous, active-high reset, sampled on the rising CLK edge.
- IMEM_INSTR  input  16  instruction word from program memory.
- IMEM_VALID  input  1  IMEM_INSTR is valid this cycle. Ignored unless IMEM_REQ=1.
- ZERO  input  1  ALU zero flag. Sampled in EXEC.
- IMEM_REQ  output  1  fetch request. Held high until IMEM_VALID.
- IMEM_ADDR  output  PC_WIDTH  equals PC.
- RD_A_SEL  output  3  register-file read port A select.
- RD_B_SEL  output  3  register-file read port B select.
- IMM  output  8  immediate field.
- IMM_SEL  output  1  ALU B operand source: 1 = IMM, 0 = port B.
- ALU_OP  output  4  ALU operation code.
- REG_SEL  output  3  write register select, to the write-enable decoder SEL.
- REG_EN  output  1  write enable, to the write-enable decoder EN.
- HALTED  output  1  core stopped.
- ILLEGAL  output  1  one-cycle pulse on an undefined opcode.

## Operation
- Instruction fields:
  - [15:12] opcode
  - [11:9] rd
  - [8:6] rs1
  - [5:3] rs2
  - [7:0] imm/addr
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <- rs1 op rs2
  - 6 LDI: rd <- imm
  - 7 JMP: PC <- addr
  - 8 JZ: if ZERO then PC <- addr, else PC+1
  - F HALT
  - 9–E illegal
- States: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - IMEM_REQ=1.
  - On an edge with IMEM_VALID=1, capture IR <- IMEM_INSTR and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drive RD_A_SEL=rs1 and RD_B_SEL=rs2.
  - Drive IMM and IMM_SEL (1 only for LDI).
  - Always go to EXEC.
- EXEC:
  - ALU_OP=opcode, held from DECODE.
  - ALU-class and LDI instructions go to WB.
  - JMP: PC <- addr, go to FETCH.
  - JZ: PC <- addr if ZERO=1, else PC+1; go to FETCH.
  - NOP: PC+1, go to FETCH.
  - Illegal opcode: ILLEGAL=1 for this cycle, treat as NOP.
  - HALT: go to HALT; PC unchanged.
- WB:
  - REG_SEL=rd and REG_EN=1 for exactly this one cycle.
  - PC <- PC+1, go to FETCH.
- HALT:
  - HALTED=1, all enables 0.
  - Leave only via RST.
- REG_EN=1 only in WB. REG_SEL is held at rd from DECODE through WB; elsewhere it holds its last value.
- RD_A_SEL, RD_B_SEL, IMM, IMM_SEL and ALU_OP are held stable from DECODE until the next DECODE.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFF+1 = 0x00. A jump to the current PC is legal.
- IMEM_VALID outside FETCH is ignored and must not disturb IR.

## Timing
- On RST:
  - State FETCH, PC=0, IR=0.
  - Outputs: IMEM_REQ=0, REG_EN=0, REG_SEL=0, RD_A_SEL=0, RD_B_SEL=0, IMM=0, IMM_SEL=0, ALU_OP=0, HALTED=0, ILLEGAL=0.
  - IMEM_REQ rises the cycle after RST deasserts.
- RST has priority over every state, including mid-WB: REG_EN is 0 from the next edge and PC is 0. A write is performed only if REG_EN was sampled high by the register file before the reset edge.
- Cycles per instruction, taking N = fetch wait cycles (N=0 when IMEM_VALID is already high at the first REQ edge):
  - ALU/LDI: 4+N.
  - NOP/JMP/JZ/illegal: 3+N.
- REG_EN is registered: it is high for the single cycle following the EXEC edge.
- IMEM_ADDR changes only on the edge leaving EXEC or WB, so it is stable throughout FETCH.

## Test plan
- Reset: hold RST 2 cycles with random inputs -> every output at its listed reset value and PC=0. One cycle after release, IMEM_REQ=1 and IMEM_ADDR=0x00.
- ADD, immediate valid: instruction 0x1650 (ADD R3,R1,R2), IMEM_VALID=1 -> RD_A_SEL=1, RD_B_SEL=2, ALU_OP=1, then REG_SEL=3 with REG_EN=1 for exactly one cycle at the 4th cycle. IMEM_ADDR then becomes 0x01.
- Fetch stall: hold IMEM_VALID=0 for 3 cycles, then deliver 0x6A2C (LDI R5,0x2C) -> IMEM_REQ held high for 4 cycles, IMM=0x2C, IMM_SEL=1. REG_SEL=5 with a single REG_EN pulse at the 7th cycle.
- Branches:
  - JZ 0x40 (0x8040) with ZERO=1 -> PC=0x40 and no REG_EN pulse.
  - Same instruction with ZERO=0 -> PC=old+1.
  - JMP 0xFF, then a NOP at 0xFF -> next IMEM_ADDR=0x00 (wrap).
- Illegal and halt: opcode 0xA -> one-cycle ILLEGAL pulse and PC+1. Then 0xF000 -> HALTED=1 and IMEM_REQ=0 for 20 or more cycles, cleared only by RST.
- Reset mid-WB: assert RST during the WB cycle of an ADD -> REG_EN=0 and PC=0 on the next edge, and the FSM restarts in FETCH.
